// File: rtl/imem_loader.sv
// Program loader and instruction store: accepts a byte stream into a 2^ADDR_W x DATA_W
// array, holds the processor in clear while loading, then serves combinational fetches.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] Read_Address,
  output logic [DATA_W-1:0] instruction,
  output logic              proc_run,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     cnt_q;
  logic                ovf_q;
  logic                done_q;
  logic                ready_q;
  logic                run_q;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic xfer;
  logic ptr_full;

  assign xfer     = (state_q == StLoad) && in_valid;
  assign ptr_full = (ptr_q == '1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StRun: begin
          // Any byte presented alongside load_start is not written on this edge.
          if (load_start) begin
            state_q <= StLoad;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            run_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (in_last || ptr_full) begin
              // Pointer is left at the final address so a full array never wraps.
              state_q <= StRun;
              ready_q <= 1'b0;
              run_q   <= 1'b1;
              done_q  <= 1'b1;
              ovf_q   <= ptr_full && !in_last;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  // Array contents survive reset so a partially loaded program stays in place.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[ptr_q] <= in_data;
    end
  end

  assign instruction = run_q ? mem[Read_Address] : '0;
  assign in_ready    = ready_q;
  assign proc_run    = run_q;
  assign load_done   = done_q;
  assign byte_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random traffic, checked
// every cycle against a byte-stream model of the loader.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] Read_Address = 8'h00;
  logic [7:0] instruction;
  logic       proc_run;
  logic       load_done;
  logic [8:0] byte_count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  imem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .Read_Address(Read_Address),
    .instruction (instruction),
    .proc_run    (proc_run),
    .load_done   (load_done),
    .byte_count  (byte_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = idle, 1 = loading, 2 = running; m_cnt bytes taken by current load.
  int         m_phase = 0;
  int         m_cnt   = 0;
  bit         m_ovf   = 1'b0;
  bit         m_done  = 1'b0;
  logic [7:0] m_mem   [256];
  bit         m_known [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_phase = 0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_phase == 1) begin
        if (in_valid) begin
          m_mem[m_cnt]   = in_data;
          m_known[m_cnt] = 1'b1;
          m_cnt++;
          if (in_last || m_cnt == 256) begin
            m_ovf   = !in_last;
            m_phase = 2;
            m_done  = 1'b1;
          end
        end
      end else if (load_start) begin
        m_phase = 1;
        m_cnt   = 0;
        m_ovf   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 1));
      check("proc_run", 32'(proc_run), 32'(m_phase == 2));
      check("load_done", 32'(load_done), 32'(m_done));
      check("byte_count", 32'(byte_count), 32'(m_cnt));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_phase != 2) check("instr_masked", 32'(instruction), 32'h0);
      else if (m_known[Read_Address]) check("instr", 32'(instruction), 32'(m_mem[Read_Address]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    @(negedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_proc_run", 32'(proc_run), 32'h0);
    check("rst_byte_count", 32'(byte_count), 32'h0);
    tick();

    // Basic load with masked fetch during LOAD
    Read_Address = 8'h00;
    start_load();
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(negedge clk);
    check("masked_instr", 32'(instruction), 32'h0);
    check("masked_run", 32'(proc_run), 32'h0);
    tick();
    in_data = 8'h22;
    tick();
    in_data = 8'h33;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    Read_Address = 8'h01;
    @(negedge clk);
    check("basic_done", 32'(load_done), 32'h1);
    check("basic_run", 32'(proc_run), 32'h1);
    check("basic_count", 32'(byte_count), 32'h3);
    check("basic_instr1", 32'(instruction), 32'h22);
    tick();
    @(negedge clk);
    check("basic_done_low", 32'(load_done), 32'h0);
    tick();

    // Reload from RUN with a single byte
    start_load();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    Read_Address = 8'h00;
    @(negedge clk);
    check("reload_count", 32'(byte_count), 32'h1);
    check("reload_mem0", 32'(instruction), 32'hAA);
    check("reload_ovf", 32'(overflow), 32'h0);
    Read_Address = 8'h01;
    #1;
    check("reload_mem1", 32'(instruction), 32'h22);
    tick();

    // Gapped valid: bytes 50,52,54,56 on alternate cycles
    start_load();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'h50 + 8'(i);
      in_last  = (i == 6);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("gap_count", 32'(byte_count), 32'h4);
    for (int a = 0; a < 4; a++) begin
      Read_Address = 8'(a);
      #1;
      check("gap_mem", 32'(instruction), 32'h50 + 32'(2 * a));
    end
    tick();

    // Overflow: 300 bytes, no last
    start_load();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    Read_Address = 8'hFF;
    #1;
    check("ovf_count", 32'(byte_count), 32'h100);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_run", 32'(proc_run), 32'h1);
    check("ovf_mem255", 32'(instruction), 32'hFF);
    tick();

    // Reset mid-load after two bytes
    start_load();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("mid_count", 32'(byte_count), 32'h2);
    clr = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    check("mid_rst_run", 32'(proc_run), 32'h0);
    check("mid_rst_count", 32'(byte_count), 32'h0);
    tick();
    clr = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_idle_ready", 32'(in_ready), 32'h0);
    check("post_rst_idle_run", 32'(proc_run), 32'h0);
    tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      load_start   = ($urandom_range(0, 15) == 0);
      in_valid     = $urandom_range(0, 1) == 1;
      in_data      = 8'($urandom);
      in_last      = ($urandom_range(0, 9) == 0);
      Read_Address = 8'($urandom);
      tick();
    end
    load_start = 1'b0;
    in_valid   = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
